qdiv_seq: RTL



---
 rtl/qdiv_seq_pkg.sv | 19 +
 rtl/qdiv_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/qdiv_seq_pkg.sv
// Shared definitions for the sequential fixed-point divider: default word
// format, FSM state encoding and small format helpers.
package qdiv_seq_pkg;

    // Default Qm.Q format, shared with the multiply/add stages.
    localparam int unsigned QDefault = 8;
    localparam int unsigned NDefault = 16;

    typedef enum logic {
        StIdle,
        StCalc
    } state_e;

    // Index of the sign bit in an n-bit sign-magnitude word.
    function automatic int unsigned sign_idx(input int unsigned n);
        return n - 1;
    endfunction

endpackage

// File: rtl/qdiv_seq.sv
// Sequential signed (sign-magnitude) Qm.Q divider. Restoring division, one
// quotient bit per clock; saturates on overflow and on divide-by-zero.
module qdiv_seq
    import qdiv_seq_pkg::*;
#(
    parameter int unsigned Q = QDefault,
    parameter int unsigned N = NDefault
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic [N-1:0] o_quotient,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_ovr,
    output logic         o_div0
);

    // Numerator / raw quotient width: magnitude bits plus Q fractional zeros.
    localparam int unsigned W    = N - 1 + Q;
    localparam int unsigned CntW = $clog2(N + Q);
    localparam int unsigned Sb   = sign_idx(N);
    localparam logic [CntW-1:0] LastCnt = CntW'(N + Q - 2);

    state_e        state_q, state_d;
    logic          sign_q, sign_d;
    logic [W-1:0]  num_q, num_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-2:0]  div_q, div_d;
    logic [N-1:0]  quot_q, quot_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;
    logic          div0_q, div0_d;

    logic [N:0]    trial;
    logic [N:0]    diff;
    logic          ge;
    logic [N-1:0]  rem_step;
    logic [W-1:0]  quo_next;
    logic          upper_nz;
    logic          start_sign;

    // One restoring step: shift in the next numerator bit, trial-subtract.
    always_comb begin
        trial    = {rem_q, num_q[W-1]};
        diff     = trial - {2'b00, div_q};
        ge       = (trial >= {2'b00, div_q});
        rem_step = ge ? diff[N-1:0] : trial[N-1:0];
        quo_next = {quo_q[W-2:0], ge};
        // Any set bit above the magnitude field means the result does not fit.
        upper_nz = |quo_next[W-1:N-1];
        start_sign = i_dividend[Sb] ^ i_divisor[Sb];
    end

    // Next-state and result logic.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        num_d   = num_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        quot_d  = quot_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
        div0_d  = div0_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    if (i_divisor[N-2:0] == '0) begin
                        // Divide-by-zero completes immediately, saturated.
                        quot_d = {start_sign, {(N-1){1'b1}}};
                        ovr_d  = 1'b1;
                        div0_d = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        sign_d  = start_sign;
                        num_d   = {i_dividend[N-2:0], {Q{1'b0}}};
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = '0;
                        div_d   = i_divisor[N-2:0];
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                num_d = num_q << 1;
                rem_d = rem_step;
                quo_d = quo_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    div0_d  = 1'b0;
                    if (upper_nz) begin
                        quot_d = {sign_q, {(N-1){1'b1}}};
                        ovr_d  = 1'b1;
                    end else begin
                        // Zero magnitude is always reported as +0.
                        quot_d = {sign_q & (|quo_next[N-2:0]), quo_next[N-2:0]};
                        ovr_d  = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            sign_q  <= 1'b0;
            num_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            quot_q  <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            num_q   <= num_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            quot_q  <= quot_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            div0_q  <= div0_d;
        end
    end

    assign o_quotient = quot_q;
    assign o_busy     = (state_q == StCalc);
    assign o_done     = done_q;
    assign o_ovr      = ovr_q;
    assign o_div0     = div0_q;

endmodule
